// File: rtl/mcp_arb_pkg.sv
// Shared types for the MCP transmit arbiter.
// Tagged word layout and counter width.
package mcp_arb_pkg;

  localparam int ARB_NUM_REQ = 4;
  localparam int ARB_DATA_W  = 8;
  localparam int ARB_ID_W    = $clog2(ARB_NUM_REQ);
  localparam int XFER_W      = 16;

  typedef struct packed {
    logic [ARB_ID_W-1:0]   id;
    logic [ARB_DATA_W-1:0] payload;
  } tagged_word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Search starts one past last_grant, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index
);

  int   pos;
  logic found;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = int'(last_grant) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (enable && !found && eligible[pos]) begin
        grant[pos] = 1'b1;
        index      = IDX_W'(pos);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mcp_tx_arbiter.sv
// Round-robin front end sharing one MCP transmitter.
// Words are tagged {id, payload} in a one-entry holding register.
module mcp_tx_arbiter
  import mcp_arb_pkg::*;
#(
  parameter int NUM_REQ    = ARB_NUM_REQ,
  parameter int DATA_WIDTH = ARB_DATA_W,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                               clk_a,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0]                 req_mask,
  input  logic                               mcp_a_ready,
  output logic                               mcp_a_send,
  output logic [ID_WIDTH+DATA_WIDTH-1:0]     mcp_a_datain,
  output logic                               busy,
  output logic [XFER_W-1:0]                  xfer_count
);

  logic                  hold_valid;
  logic [ID_WIDTH-1:0]   hold_id;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [ID_WIDTH-1:0]   last_grant;

  logic                  drain;
  logic                  can_accept;
  logic                  accept;
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_WIDTH-1:0]   win_idx;

  assign eligible   = req_valid & req_mask;
  assign drain      = hold_valid & mcp_a_ready;
  assign can_accept = (~hold_valid | drain) & ~reset;
  assign accept     = |grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_WIDTH)
  ) u_rr (
    .eligible   (eligible),
    .last_grant (last_grant),
    .enable     (can_accept),
    .grant      (grant),
    .index      (win_idx)
  );

  assign req_ready    = grant;
  assign mcp_a_send   = drain;
  assign mcp_a_datain = {hold_id, hold_data};
  assign busy         = hold_valid;

  // last_grant starts at the top index so requester 0 wins first
  always_ff @(posedge clk_a or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_id    <= '0;
      hold_data  <= '0;
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_id    <= win_idx;
      hold_data  <= req_data[win_idx];
      last_grant <= win_idx;
    end else if (drain) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_a or posedge reset) begin
    if (reset) begin
      xfer_count <= '0;
    end else if (drain && xfer_count != '1) begin
      xfer_count <= xfer_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mcp_tx_arbiter.sv
// Directed self-checking bench for mcp_tx_arbiter.
// Each task drives one scenario and checks inline.
module tb_mcp_tx_arbiter;
  import mcp_arb_pkg::*;

  logic             clk_a = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       req_valid = '0;
  logic [3:0][7:0]  req_data = '0;
  logic [3:0]       req_ready;
  logic [3:0]       req_mask = '0;
  logic             mcp_a_ready = 1'b0;
  logic             mcp_a_send;
  logic [9:0]       mcp_a_datain;
  logic             busy;
  logic [15:0]      xfer_count;

  int checks = 0;
  int errors = 0;

  always #5 clk_a = ~clk_a;

  mcp_tx_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8)
  ) dut (
    .clk_a        (clk_a),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .req_mask     (req_mask),
    .mcp_a_ready  (mcp_a_ready),
    .mcp_a_send   (mcp_a_send),
    .mcp_a_datain (mcp_a_datain),
    .busy         (busy),
    .xfer_count   (xfer_count)
  );

  task automatic tick;
    @(posedge clk_a);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    req_valid   = 4'hF;
    req_mask    = 4'hF;
    mcp_a_ready = 1'b1;
    req_data    = {8'h13, 8'h12, 8'h11, 8'h10};
    reset       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (req_ready !== 4'b0 || mcp_a_send !== 1'b0 ||
          xfer_count !== 16'h0) begin
        errors++;
        $display("FAIL reset_outs: ready=%b send=%b cnt=%h want 0/0/0",
                 req_ready, mcp_a_send, xfer_count);
      end
    end
    checks++;
    if (busy !== 1'b0 || mcp_a_datain !== 10'h0) begin
      errors++;
      $display("FAIL reset_hold: busy=%b din=%h want 0/000",
               busy, mcp_a_datain);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: got %b want 0001", req_ready);
    end
    tick();
    req_valid = 4'hE;
    #1;
    checks++;
    if (mcp_a_send !== 1'b1 || mcp_a_datain !== 10'h010) begin
      errors++;
      $display("FAIL reset_first_word: send=%b din=%h want 1/010",
               mcp_a_send, mcp_a_datain);
    end
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL reset_second_grant: got %b want 0010", req_ready);
    end
  endtask

  task automatic test_round_robin;
    int n;
    int cnt;
    logic nr;
    tagged_word_t tw;
    req_valid   = 4'hF;
    req_mask    = 4'hF;
    req_data    = {8'h13, 8'h12, 8'h11, 8'h10};
    mcp_a_ready = 1'b1;
    do_reset();
    nr  = 1'b1;
    n   = 0;
    cnt = 0;
    for (int g = 0; g < 80 && n < 8; g++) begin
      mcp_a_ready = nr;
      #1;
      checks++;
      if (mcp_a_send && !mcp_a_ready) begin
        errors++;
        $display("FAIL rr_spurious_send: send=1 ready=0 want send=0");
      end
      if (mcp_a_send === 1'b1) begin
        tw = mcp_a_datain;
        checks++;
        if (tw.id !== 2'(n % 4) || tw.payload !== 8'(16 + n % 4)) begin
          errors++;
          $display("FAIL rr_order[%0d]: id=%0d pl=%h want %0d/%h",
                   n, tw.id, tw.payload, n % 4, 8'(16 + n % 4));
        end
        n++;
        nr  = 1'b0;
        cnt = 2;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) nr = 1'b1;
      end
      tick();
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL rr_timeout: got %0d sends want 8", n);
    end
    req_valid = '0;
  endtask

  task automatic test_back_to_back;
    req_valid   = 4'b0100;
    req_mask    = 4'hF;
    req_data    = '0;
    req_data[2] = 8'h20;
    mcp_a_ready = 1'b1;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      tick();
      req_data[2] = 8'(32 + k);
      #1;
      checks++;
      if (mcp_a_send !== 1'b1 || req_ready !== 4'b0100 ||
          xfer_count !== 16'(k - 1) ||
          mcp_a_datain !== {2'd2, 8'(32 + k - 1)}) begin
        errors++;
        $display("FAIL b2b[%0d]: send=%b rdy=%b cnt=%0d din=%h want 1/0100/%0d/%h",
                 k, mcp_a_send, req_ready, xfer_count, mcp_a_datain,
                 k - 1, {2'd2, 8'(32 + k - 1)});
      end
    end
    req_valid = '0;
  endtask

  task automatic test_mask;
    req_valid   = 4'b0010;
    req_mask    = 4'b1101;
    req_data    = '0;
    req_data[1] = 8'h5A;
    mcp_a_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (req_ready !== 4'b0 || mcp_a_send !== 1'b0) begin
        errors++;
        $display("FAIL mask_hold[%0d]: rdy=%b send=%b want 0000/0",
                 i, req_ready, mcp_a_send);
      end
      tick();
    end
    req_mask = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL mask_release: rdy=%b want 0010", req_ready);
    end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (mcp_a_send !== 1'b1 || mcp_a_datain !== 10'h15A) begin
      errors++;
      $display("FAIL mask_word: send=%b din=%h want 1/15a",
               mcp_a_send, mcp_a_datain);
    end
  endtask

  task automatic test_stall;
    int sends;
    req_valid   = 4'b0001;
    req_mask    = 4'hF;
    req_data    = '0;
    req_data[0] = 8'h33;
    mcp_a_ready = 1'b0;
    do_reset();
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL stall_accept: rdy=%b want 0001", req_ready);
    end
    tick();
    req_valid   = 4'b0001;
    req_data[0] = 8'h44;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (busy !== 1'b1 || req_ready !== 4'b0 || mcp_a_send !== 1'b0 ||
          mcp_a_datain !== 10'h033) begin
        errors++;
        $display("FAIL stall[%0d]: busy=%b rdy=%b send=%b din=%h want 1/0000/0/033",
                 i, busy, req_ready, mcp_a_send, mcp_a_datain);
      end
      tick();
    end
    req_valid   = '0;
    mcp_a_ready = 1'b1;
    sends       = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (mcp_a_send === 1'b1) sends++;
      tick();
    end
    checks++;
    if (sends != 1 || xfer_count !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: sends=%0d cnt=%0d busy=%b want 1/1/0",
               sends, xfer_count, busy);
    end
  endtask

  task automatic test_saturate;
    req_valid   = 4'b0001;
    req_mask    = 4'hF;
    req_data    = '0;
    req_data[0] = 8'h77;
    mcp_a_ready = 1'b1;
    do_reset();
    repeat (65535) tick();
    checks++;
    if (xfer_count !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_pre: cnt=%h want fffe", xfer_count);
    end
    tick();
    checks++;
    if (xfer_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_max: cnt=%h want ffff", xfer_count);
    end
    repeat (3) tick();
    checks++;
    if (xfer_count !== 16'hFFFF || mcp_a_send !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold: cnt=%h send=%b want ffff/1",
               xfer_count, mcp_a_send);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_mask();
    test_stall();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcp_tx_arbiter.md
# mcp_tx_arbiter

Round-robin arbiter that shares one multi-cycle-path (MCP) clock-domain-crossing transmitter between NUM_REQ requesters in the clk_a domain. It accepts valid/ready words from each requester, tags each word with the requester index, and drives the MCP transmit side (a_send/a_datain/a_ready), so several clk_a sources can use one crossing. It sits in the CPU clock domain, directly in front of the MCP instance. The receive side decodes the tag from b_data.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_WIDTH, 8: payload width per requester.
- ID_WIDTH, $clog2(NUM_REQ): tag width, derived; not to be overridden.

Ports:
- clk_a  input  1  transmit-domain clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high.
- req_valid  input  NUM_REQ  per-requester word valid.
- req_data  input  NUM_REQ x DATA_WIDTH  per-requester payload.
- req_ready  output  NUM_REQ  one-hot; the word is accepted in the cycle req_valid[i] & req_ready[i].
- req_mask  input  NUM_REQ  1 = requester eligible for grant.
- mcp_a_ready  input  1  from MCP a_ready.
- mcp_a_send  output  1  to MCP a_send.
- mcp_a_datain  output  ID_WIDTH+DATA_WIDTH  to MCP a_datain, laid out as {id, payload}.
- busy  output  1  holding register occupied.
- xfer_count  output  16  saturating count of words handed to MCP.

## Operation
- One-entry holding register: hold_valid, hold_id, hold_data.
- mcp_a_send = hold_valid & mcp_a_ready (combinational). A transfer ("drain") occurs in any cycle where mcp_a_send = 1.
  - mcp_a_send is never asserted while mcp_a_ready = 0. The MCP sets its busy flag on any a_send, so spurious sends are forbidden.
- mcp_a_datain = {hold_id, hold_data} at all times. It is only meaningful while hold_valid = 1.
- Eligible set: E = req_valid & req_mask.
- Accept is permitted in a cycle when hold_valid = 0, or when a drain occurs in that same cycle (back-to-back).
- Round-robin pick: search E starting at (last_grant+1) mod NUM_REQ, in ascending order with wrap. The first set bit wins.
- req_ready = one-hot(winner) when accept is permitted and E != 0; otherwise all zeros.
- On accept:
  - hold_data <= req_data[winner], hold_id <= winner, hold_valid <= 1.
  - last_grant <= winner.
- On drain without accept: hold_valid <= 0.
- xfer_count increments on each drain and saturates at 16'hFFFF.
- Requester rule: once req_valid[i] rises, req_valid[i] and req_data[i] hold until accepted. Masking a requester while it is pending is legal; its word stays pending.
- Changing req_mask never affects a word already in the holding register.

## Timing
- Reset values:
  - hold_valid = 0, busy = 0, mcp_a_send = 0.
  - req_ready = 0, mcp_a_datain = 0, xfer_count = 0.
  - last_grant = NUM_REQ-1, so requester 0 wins the first contention.
- Accept-to-send latency: 1 cycle minimum. A word accepted at edge N can drain in cycle N+1 if mcp_a_ready = 1.
- Throughput is bounded by the MCP handshake. mcp_a_ready drops the cycle after a drain and returns only when the MCP acknowledges. The arbiter keeps the next word in the holding register until then.
- Simultaneous drain and accept: both take effect at the same edge, and hold_valid stays 1.
- Reset mid-operation: the held word is discarded and pending requesters re-arbitrate from requester 0. The MCP must share the same reset.
- No combinational path from req_valid/req_data to mcp_a_send/mcp_a_datain. The only combinational input-to-output paths are:
  - mcp_a_ready -> mcp_a_send.
  - req_valid/req_mask/mcp_a_ready -> req_ready.

## Structure
- Package mcp_arb_pkg holds:
  - A typedef for the tagged word as a packed struct {id, payload}, parameterised through localparams.
  - The xfer_count width constant (16).
- Sub-module rr_arbiter(NUM_REQ): inputs eligible vector, last_grant and enable; outputs one-hot grant and encoded index. It is purely combinational and reusable elsewhere.
- The top level holds the holding register, last_grant, the counter and the MCP-facing glue.

## Test plan
- Reset with all inputs active -> req_ready = 0, mcp_a_send = 0 and xfer_count = 0 while reset is high. After release, requester 0 is accepted first.
- NUM_REQ=4, all four valid continuously with payloads 8'h10..8'h13, MCP ack 3 cycles after each send -> MCP receives tags in order 0,1,2,3,0,… with matching payloads. mcp_a_send is never asserted while mcp_a_ready = 0.
- Only requester 2 valid, mcp_a_ready held at 1 -> back-to-back accepts every cycle, with drain and accept at the same edge. xfer_count rises by 1 per cycle.
- Requester 1 pending, req_mask[1] = 0 for 10 cycles, then set to 1 -> no grant to requester 1 while masked. It is accepted the cycle after unmasking, and its data is unchanged.
- Hold mcp_a_ready low with a word held -> busy = 1, req_ready = 0, and mcp_a_datain stable. Raising mcp_a_ready gives exactly one send.
- Force 65535 drains, then one more -> xfer_count = 16'hFFFF and does not wrap.
